// File: rtl/mux_lut_array.sv
// Bank of N reprogrammable K-input LUT cells (2^K:1 mux trees fed by config bits).
// Configuration shifts in serially through a shadow chain and is committed in a single cycle.
module mux_lut_array #(
  parameter int unsigned K       = 2,
  parameter int unsigned N       = 4,
  parameter int unsigned REG_OUT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*K-1:0] in_data,
  input  logic           in_valid,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           cfg_start,
  input  logic           cfg_en,
  input  logic           cfg_din,
  output logic           cfg_busy,
  output logic           cfg_done
);

  localparam int unsigned DEPTH    = 1 << K;
  localparam int unsigned CFG_BITS = N * DEPTH;
  localparam int unsigned CW       = $clog2(CFG_BITS) + 1;

  // Every even entry is 1, every odd entry 0: each cell inverts its select bit 0.
  localparam logic [CFG_BITS-1:0] NOT_CFG  = {(CFG_BITS / 2){2'b01}};
  localparam logic [CW-1:0]       CNT_LAST = CW'(CFG_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [N-1:0]        out_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= NOT_CFG;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // A restart takes priority over a bit presented in the same cycle.
        if (cfg_start) begin
          cnt_d = '0;
        end else if (cfg_en) begin
          shadow_d = {shadow_q[CFG_BITS-2:0], cfg_din};
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_busy = (state_q != IDLE);
  assign cfg_done = (state_q == COMMIT);

  for (genvar c = 0; c < N; c++) begin : g_cell
    logic [DEPTH-1:0] cell_tt;
    logic [K-1:0]     cell_sel;
    assign cell_tt       = active_q[c*DEPTH +: DEPTH];
    assign cell_sel      = in_data[c*K +: K];
    assign out_data_d[c] = cell_tt[cell_sel];
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [N-1:0] out_data_q;
    logic         out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= in_valid;
      end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
  end else begin : g_comb_out
    assign out_data  = out_data_d;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_mux_lut_array.sv
// Bench for mux_lut_array: registered K=2/N=4 instance and combinational K=1/N=8 instance
// share one stimulus stream and are checked every cycle against a truth-table model.
module tb_mux_lut_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       cfg_start, cfg_en, cfg_din;

  logic [3:0] out_data_a;
  logic       out_valid_a, cfg_busy_a, cfg_done_a;
  logic [7:0] out_data_b;
  logic       out_valid_b, cfg_busy_b, cfg_done_b;

  int vectors = 0;
  int miscompares = 0;
  int busy_seen = 0;
  int done_seen = 0;
  logic chk_en = 1'b0;
  logic fix_in = 1'b0;

  always #5 clk = ~clk;

  mux_lut_array #(.K(2), .N(4), .REG_OUT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_a), .out_valid(out_valid_a),
    .cfg_start(cfg_start), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_busy(cfg_busy_a), .cfg_done(cfg_done_a)
  );

  mux_lut_array #(.K(1), .N(8), .REG_OUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data_b), .out_valid(out_valid_b),
    .cfg_start(cfg_start), .cfg_en(cfg_en), .cfg_din(cfg_din),
    .cfg_busy(cfg_busy_b), .cfg_done(cfg_done_b)
  );

  // Truth-table lookup: cell c reads table entry c*2^k + (its k-bit select field).
  function automatic logic [7:0] lut_eval(input logic [15:0] act, input logic [7:0] din, input int k);
    logic [7:0] r;
    int sel;
    r = '0;
    for (int c = 0; c < 8 / k; c++) begin
      sel  = int'(din >> (c * k)) & ((1 << k) - 1);
      r[c] = act[c * (1 << k) + sel];
    end
    return r;
  endfunction

  // Both instances hold 16 config bits, so one configuration model serves both.
  logic        m_loading, m_commit;
  int          m_nbits;
  logic [15:0] m_shadow, m_active;
  logic [3:0]  m_out;
  logic        m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b0;
      m_commit  <= 1'b0;
      m_nbits   <= 0;
      m_shadow  <= '0;
      m_active  <= 16'h5555;
      m_out     <= '0;
      m_ov      <= 1'b0;
    end else begin
      m_out <= 4'(lut_eval(m_active, in_data, 2));
      m_ov  <= in_valid;
      if (m_commit) begin
        m_active <= m_shadow;
        m_commit <= 1'b0;
      end else if (m_loading) begin
        if (cfg_start) begin
          m_nbits <= 0;
        end else if (cfg_en) begin
          m_shadow <= {m_shadow[14:0], cfg_din};
          m_nbits  <= m_nbits + 1;
          if (m_nbits == 15) begin
            m_loading <= 1'b0;
            m_commit  <= 1'b1;
          end
        end
      end else if (cfg_start) begin
        m_loading <= 1'b1;
        m_nbits   <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_out", 8'(out_data_a), 8'(m_out));
      check("a_valid", 8'(out_valid_a), 8'(m_ov));
      check("a_busy", 8'(cfg_busy_a), 8'(m_loading | m_commit));
      check("a_done", 8'(cfg_done_a), 8'(m_commit));
      check("b_out", out_data_b, lut_eval(m_active, in_data, 1));
      check("b_valid", 8'(out_valid_b), 8'(in_valid));
      check("b_busy", 8'(cfg_busy_b), 8'(m_loading | m_commit));
      check("b_done", 8'(cfg_done_b), 8'(m_commit));
      if (cfg_busy_a) busy_seen++;
      if (cfg_done_a) done_seen++;
    end
  end

  task automatic step();
    if (!fix_in) begin
      in_data  = 8'($urandom);
      in_valid = 1'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] cfg, input int gap, input int restart_at);
    cfg_start = 1'b1;
    cfg_en    = 1'b1;
    cfg_din   = 1'($urandom);
    step();
    cfg_start = 1'b0;
    if (restart_at > 0) begin
      for (int r = 0; r < restart_at; r++) begin
        cfg_en  = 1'b1;
        cfg_din = 1'($urandom);
        step();
      end
      cfg_start = 1'b1;
      cfg_en    = 1'b1;
      step();
      cfg_start = 1'b0;
    end
    for (int i = 15; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) begin
        cfg_en  = 1'b0;
        cfg_din = 1'($urandom);
        step();
      end
      cfg_en  = 1'b1;
      cfg_din = cfg[i];
      step();
    end
    cfg_en    = 1'b1;
    cfg_din   = 1'($urandom);
    cfg_start = 1'($urandom);
    step();
    cfg_start = 1'b0;
    cfg_en    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b0, d0;
    rst_n = 1'b1; cfg_start = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0;
    in_data = '0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_out", 8'(out_data_a), 8'h00);
    check("rst_a_busy", 8'(cfg_busy_a), 8'h00);
    check("rst_a_done", 8'(cfg_done_a), 8'h00);
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;

    // Reset config is NOT on select bit 0.
    fix_in = 1'b1; in_data = 8'b00_01_10_11; in_valid = 1'b1;
    #1 check("not_b_comb", out_data_b, 8'hE4);
    step();
    check("not_a", 8'(out_data_a), 8'h0A);
    check("not_a_valid", 8'(out_valid_a), 8'h01);
    in_valid = 1'b0;
    step();
    check("not_a_valid_low", 8'(out_valid_a), 8'h00);

    // Gapped AND load: old config must persist until after the commit.
    in_valid = 1'b1;
    d0 = done_seen;
    load(16'h8888, 3, 0);
    check("gap_old_cfg", 8'(out_data_a), 8'h0A);
    check("gap_done_once", 8'(done_seen - d0), 8'd1);
    step();
    check("gap_new_cfg", 8'(out_data_a), 8'h01);

    // Back-to-back AND load: 17 busy cycles, single done pulse.
    fix_in = 1'b0;
    b0 = busy_seen; d0 = done_seen;
    load(16'h8888, 0, 0);
    check("and_busy_cycles", 8'(busy_seen - b0), 8'd17);
    check("and_done_once", 8'(done_seen - d0), 8'd1);
    fix_in = 1'b1; in_valid = 1'b1;
    in_data = 8'hFF; step();
    check("and_ff", 8'(out_data_a), 8'h0F);
    in_data = 8'h5A; step();
    check("and_5a", 8'(out_data_a), 8'h00);

    // Restart after 7 bits, then XOR.
    fix_in = 1'b0;
    d0 = done_seen;
    load(16'h6666, 0, 7);
    check("xor_done_once", 8'(done_seen - d0), 8'd1);
    fix_in = 1'b1; in_data = 8'b00_01_10_11; in_valid = 1'b1;
    step();
    check("xor_a", 8'(out_data_a), 8'h06);

    // Asynchronous reset after 9 accepted bits.
    fix_in = 1'b0;
    d0 = done_seen;
    cfg_start = 1'b1; cfg_en = 1'b0; step();
    cfg_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cfg_en = 1'b1; cfg_din = 1'($urandom); step();
    end
    cfg_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 8'(cfg_busy_a), 8'h00);
    check("midrst_out", 8'(out_data_a), 8'h00);
    check("midrst_valid", 8'(out_valid_a), 8'h00);
    step();
    step();
    rst_n = 1'b1;
    fix_in = 1'b1; in_data = 8'b00_01_10_11; in_valid = 1'b1;
    step();
    check("midrst_not", 8'(out_data_a), 8'h0A);
    step();
    check("midrst_no_done", 8'(done_seen - d0), 8'd0);

    // Identity load on the combinational K=1 instance.
    fix_in = 1'b0;
    load(16'hAAAA, 0, 0);
    fix_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'($urandom); in_valid = 1'($urandom);
      #1;
      check("ident_b_out", out_data_b, in_data);
      check("ident_b_valid", 8'(out_valid_b), 8'(in_valid));
      step();
    end

    // Random configurations, gaps and restarts.
    fix_in = 1'b0;
    for (int n = 0; n < 8; n++) begin
      d0 = done_seen;
      load(16'($urandom), int'($urandom_range(0, 2)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0);
      check("rand_done_once", 8'(done_seen - d0), 8'd1);
      repeat (12) step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
